// File: rtl/mem_byte_serializer.sv
// Byte-serialising adapter between a 32-bit load/store core port and a byte-wide memory.
// Each access issues 1, 2 or 4 little-endian byte requests, one outstanding at a time.
module mem_byte_serializer #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_request,
  input  logic                  i_write,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [31:0]           i_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [31:0]           o_rdata,
  output logic                  o_mem_request,
  output logic                  o_mem_write,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic [7:0]            o_mem_data,
  input  logic [7:0]            i_mem_data,
  input  logic                  i_mem_data_DV
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [1:0]            k_q, k_d;
  logic [1:0]            last_q, last_d;
  logic                  write_q, write_d;
  logic [1:0]            size_q, size_d;
  logic                  zext_q, zext_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           asm_q, asm_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_data_q, mem_data_d;

  logic [1:0]  k_inc;
  logic [31:0] asm_next;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    k_d         = k_q;
    last_d      = last_q;
    write_d     = write_q;
    size_d      = size_q;
    zext_d      = zext_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    rdata_d     = rdata_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;

    k_inc    = k_q + 2'd1;
    asm_next = asm_q;
    asm_next[{k_q, 3'b000} +: 8] = i_mem_data;

    case (state_q)
      ST_IDLE: begin
        if (i_request) begin
          write_d     = i_write;
          size_d      = i_size;
          zext_d      = i_unsigned;
          addr_d      = i_address;
          wdata_d     = i_wdata;
          k_d         = 2'd0;
          last_d      = (i_size == 2'b00) ? 2'd0 : (i_size == 2'b01) ? 2'd1 : 2'd3;
          asm_d       = '0;
          mem_write_d = i_write;
          mem_addr_d  = i_address;
          mem_data_d  = i_wdata[7:0];
          state_d     = ST_REQ;
        end
      end
      ST_REQ: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_mem_data_DV) begin
          if (!write_q) asm_d = asm_next;
          if (k_q == last_q) begin
            state_d = ST_DONE;
            if (!write_q) begin
              // Extension is applied to the freshly completed assembly, including this byte.
              case (size_q)
                2'b00:   rdata_d = {{24{asm_next[7] & ~zext_q}}, asm_next[7:0]};
                2'b01:   rdata_d = {{16{asm_next[15] & ~zext_q}}, asm_next[15:0]};
                default: rdata_d = asm_next;
              endcase
            end
          end else begin
            k_d        = k_inc;
            mem_addr_d = addr_q + ADDR_WIDTH'(k_inc);
            mem_data_d = wdata_q[{k_inc, 3'b000} +: 8];
            state_d    = ST_REQ;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the assembly buffer is a plain register, so it is reset along with the control state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      last_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= '0;
      zext_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      rdata_q     <= '0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values of the others.
      state_q     <= state_d;
      k_q         <= k_d;
      last_q      <= last_d;
      write_q     <= write_d;
      size_q      <= size_d;
      zext_q      <= zext_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      rdata_q     <= rdata_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
    end
  end

  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = (state_q == ST_DONE);
  assign o_mem_request = (state_q == ST_REQ);
  assign o_mem_write   = mem_write_q;
  assign o_mem_address = mem_addr_q;
  assign o_mem_data    = mem_data_q;
  assign o_rdata       = rdata_q;

endmodule

// File: tb/tb_mem_byte_serializer.sv
// Scoreboard bench for mem_byte_serializer: directed accesses push expected byte requests
// and completions; a monitor checks them as the DUT presents them.
module tb_mem_byte_serializer;

  localparam int AW = 13;

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [7:0]    d;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
  } done_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_request = 1'b0;
  logic          i_write = 1'b0;
  logic [1:0]    i_size = 2'b00;
  logic          i_unsigned = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [31:0]   i_wdata = '0;
  logic          o_busy, o_done, o_mem_request, o_mem_write;
  logic [31:0]   o_rdata;
  logic [AW-1:0] o_mem_address;
  logic [7:0]    o_mem_data;
  logic [7:0]    i_mem_data = '0;
  logic          dv_resp = 1'b0;
  logic          dv_stray = 1'b0;
  logic          i_mem_data_DV;

  assign i_mem_data_DV = dv_resp | dv_stray;

  mem_byte_serializer #(.ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_request(i_request), .i_write(i_write),
    .i_size(i_size), .i_unsigned(i_unsigned), .i_address(i_address), .i_wdata(i_wdata),
    .o_busy(o_busy), .o_done(o_done), .o_rdata(o_rdata), .o_mem_request(o_mem_request),
    .o_mem_write(o_mem_write), .o_mem_address(o_mem_address), .o_mem_data(o_mem_data),
    .i_mem_data(i_mem_data), .i_mem_data_DV(i_mem_data_DV)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          accept_cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          req_seen = 0;
  int          dv_delay = 1;
  logic [31:0] last_rdata = '0;
  logic [7:0]  mem [0:(1<<AW)-1];
  req_t        sb_req[$];
  done_t       sb_done[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: one outstanding request, DV after dv_delay cycles.
  always begin
    logic [AW-1:0] a;
    @(negedge clk);
    if (rst_n && o_mem_request) begin
      a = o_mem_address;
      if (o_mem_write) mem[a] = o_mem_data;
      repeat (dv_delay) @(posedge clk);
      #1;
      i_mem_data = mem[a];
      dv_resp    = 1'b1;
      @(posedge clk);
      #1 dv_resp = 1'b0;
    end
  end

  // Monitor: compares every byte request and completion against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_mem_request) begin
        req_seen++;
        if (sb_req.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_mem_request: got addr 0x%04h, expected no request", o_mem_address);
        end else begin
          req_t e;
          e = sb_req.pop_front();
          check("mem_address", 32'(o_mem_address), 32'(e.a));
          check("mem_write", 32'(o_mem_write), 32'(e.w));
          if (e.w) check("mem_data", 32'(o_mem_data), 32'(e.d));
        end
      end
      if (o_done) begin
        done_cnt++;
        if (sb_done.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got o_done=1, expected none");
        end else begin
          done_t d;
          d = sb_done.pop_front();
          check("rdata", o_rdata, d.rdata);
          check("done_latency", 32'(cyc - accept_cyc + 1), 32'(d.lat));
          check("requests_left_at_done", 32'(sb_req.size()), 32'd0);
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [1:0] size, input logic uns,
                       input logic [AW-1:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input int lat);
    int    n;
    req_t  r;
    done_t d;
    logic [31:0] sh;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    for (int k = 0; k < n; k++) begin
      sh  = wdata >> (8 * k);
      r.w = w;
      r.a = addr + AW'(k);
      r.d = sh[7:0];
      sb_req.push_back(r);
    end
    d.rdata = exp_rdata;
    d.lat   = lat;
    sb_done.push_back(d);
    last_rdata = exp_rdata;
    i_request  = 1'b1;
    i_write    = w;
    i_size     = size;
    i_unsigned = uns;
    i_address  = addr;
    i_wdata    = wdata;
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    i_request  = 1'b0;
  endtask

  task automatic wait_done();
    int start;
    start = done_cnt;
    for (int i = 0; i < 300 && done_cnt == start; i++) @(posedge clk);
    #1;
    check("done_seen_within_bound", 32'(done_cnt != start), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && o_busy; i++) begin
      @(posedge clk);
      #1;
    end
    check("idle_within_bound", 32'(o_busy), 32'd0);
  endtask

  task automatic run(input logic w, input logic [1:0] size, input logic uns,
                     input logic [AW-1:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input int lat);
    issue(w, size, uns, addr, wdata, exp_rdata, lat);
    wait_done();
    wait_idle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_rdata"}, o_rdata, 32'd0);
    check({tag, "_mem_request"}, 32'(o_mem_request), 32'd0);
    check({tag, "_mem_write"}, 32'(o_mem_write), 32'd0);
    check({tag, "_mem_address"}, 32'(o_mem_address), 32'd0);
    check({tag, "_mem_data"}, 32'(o_mem_data), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    mem[13'h020] = 8'h80;
    mem[13'h030] = 8'h01;
    mem[13'h031] = 8'h80;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Word store then load back; rdata stays 0 across the store.
    run(1'b1, 2'b10, 1'b0, 13'h010, 32'hA1B2C3D4, 32'h0000_0000, 9);
    run(1'b0, 2'b10, 1'b0, 13'h010, 32'h0, 32'hA1B2C3D4, 9);

    // Byte and half loads with both extension modes; size 11 acts as word.
    run(1'b0, 2'b00, 1'b0, 13'h020, 32'h0, 32'hFFFF_FF80, 3);
    run(1'b0, 2'b00, 1'b1, 13'h020, 32'h0, 32'h0000_0080, 3);
    run(1'b0, 2'b01, 1'b0, 13'h030, 32'h0, 32'hFFFF_8001, 5);
    run(1'b0, 2'b01, 1'b1, 13'h030, 32'h0, 32'h0000_8001, 5);
    run(1'b0, 2'b11, 1'b0, 13'h010, 32'h0, 32'hA1B2C3D4, 9);

    // Address wrap at the top of the memory; store leaves rdata untouched.
    run(1'b1, 2'b10, 1'b0, 13'h1FFE, 32'h11223344, 32'hA1B2C3D4, 9);
    check("wrap_byte_0001", 32'(mem[13'h0001]), 32'h11);
    run(1'b0, 2'b10, 1'b0, 13'h1FFE, 32'h0, 32'h11223344, 9);

    // Slow memory plus a request pulse while busy that must be dropped.
    dv_delay = 5;
    issue(1'b0, 2'b10, 1'b0, 13'h010, 32'h0, 32'hA1B2C3D4, 25);
    repeat (3) @(posedge clk);
    #1;
    i_request = 1'b1;
    i_write   = 1'b1;
    i_address = 13'h100;
    @(posedge clk);
    #1;
    i_request = 1'b0;
    wait_done();
    wait_idle();
    dv_delay = 1;

    // Stray DV while idle.
    dv_stray = 1'b1;
    @(posedge clk);
    #1;
    dv_stray = 1'b0;
    check("stray_dv_busy", 32'(o_busy), 32'd0);
    check("stray_dv_mem_request", 32'(o_mem_request), 32'd0);
    @(posedge clk);
    #1;
    check("stray_dv_done", 32'(o_done), 32'd0);
    check("stray_dv_rdata", o_rdata, last_rdata);

    // Reset while waiting on the second byte of a slow word store.
    dv_delay = 5;
    begin
      int base;
      base = req_seen;
      issue(1'b1, 2'b10, 1'b0, 13'h040, 32'h55667788, 32'h0, 99);
      for (int i = 0; i < 100 && req_seen < base + 2; i++) @(posedge clk);
      check("second_request_seen", 32'(req_seen - base), 32'd2);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb_req.delete();
    sb_done.delete();
    #1;
    check_all_zero("midop_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_rdata = 32'h0;
    repeat (10) @(posedge clk);
    #1;
    check("after_late_dv_busy", 32'(o_busy), 32'd0);
    check("after_late_dv_done_count_quiet", 32'(o_done), 32'd0);
    dv_delay = 1;
    run(1'b0, 2'b00, 1'b1, 13'h020, 32'h0, 32'h0000_0080, 3);

    repeat (3) @(posedge clk);
    #1;
    check("sb_req_empty_at_end", 32'(sb_req.size()), 32'd0);
    check("sb_done_empty_at_end", 32'(sb_done.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
